// File: rtl/spi_clk_pkg.sv
// Shared widths and helpers for the SPI serial-clock generator.
package spi_clk_pkg;

  // Width of the divider select input.
  localparam int DIV_W = 3;
  // Width of the half-period counter (largest half-period is 128 clk cycles).
  localparam int CNT_W = 7;

  // Terminal count of the half-period counter: 2^div - 1.
  // Computed one bit wider so div = 7 does not overflow before the decrement.
  function automatic logic [CNT_W-1:0] half_period(input logic [DIV_W-1:0] div);
    logic [CNT_W:0] w_pow;
    logic [CNT_W:0] w_dec;
    w_pow = {{CNT_W{1'b0}}, 1'b1} << div;
    w_dec = w_pow - {{CNT_W{1'b0}}, 1'b1};
    return w_dec[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sclk_edge_detect.sv
// Rising/falling edge strobes for a registered signal, gated by a
// registered run qualifier so forced level changes while idle (or at the
// moment of leaving run) never produce a strobe.
module sclk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  input  logic run,
  output logic pe,
  output logic ne
);

  logic r_sig_q;
  logic r_run_q;

  // Delay the signal and the run qualifier by one clk cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig_q <= 1'b0;
      r_run_q <= 1'b0;
    end else begin
      r_sig_q <= sig;
      r_run_q <= run;
    end
  end

  // Both inputs are flop outputs, so these strobes are glitch-free and
  // can never be high together.
  assign pe = sig & ~r_sig_q & r_run_q;
  assign ne = ~sig & r_sig_q & r_run_q;

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides clk by 2^(divider+1) while chip
// select is low, idles at cpol otherwise, and emits one-cycle edge strobes
// that coincide with the new sclk level.
// Optional feature: define SPI_SCLK_CS_SYNC_EN to pass cs through a
// 2-flop synchronizer (adds 2 cycles to both run entry and run exit).
module spi_sclk_gen
  import spi_clk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divider,
  input  logic             cpol,
  input  logic             cs,
  output logic             sclk,
  output logic             sclk_pe,
  output logic             sclk_ne
);

  logic             w_cs_eff;
  logic             w_run;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;

`ifdef SPI_SCLK_CS_SYNC_EN
  logic r_cs_s1;
  logic r_cs_s2;

  // Two-flop synchronizer; resets to the idle (deselected) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_s1 <= 1'b1;
      r_cs_s2 <= 1'b1;
    end else begin
      r_cs_s1 <= cs;
      r_cs_s2 <= r_cs_s1;
    end
  end

  assign w_cs_eff = r_cs_s2;
`else
  assign w_cs_eff = cs;
`endif

  assign w_run   = ~w_cs_eff;
  assign w_limit = half_period(divider);

  // Half-period counter and sclk register. Idle forces sclk to cpol and
  // clears the count; cpol is therefore only observed while idle. If the
  // divider shrinks below the current count mid-run, the counter simply
  // runs on and wraps through zero before matching again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_cs_eff) begin
      r_cnt  <= '0;
      r_sclk <= cpol;
    end else if (r_cnt == w_limit) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign sclk = r_sclk;

  sclk_edge_detect u_edge (
    .clk (clk),
    .rst (rst),
    .sig (r_sclk),
    .run (w_run),
    .pe  (sclk_pe),
    .ne  (sclk_ne)
  );

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Testbench for spi_sclk_gen: vector table of run scenarios plus
// hand-written reset, cpol-change and mid-run reset sequences. A cycle
// model pushes the expected {sclk, sclk_pe, sclk_ne} per edge into a queue;
// each sample after the edge pops and compares.
module tb_spi_sclk_gen;

`ifdef SPI_SCLK_CS_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct {
    string      name;
    logic [2:0] div;
    logic       cpol;
    int         run;
    int         exp_first;
    int         exp_pe;
    int         exp_ne;
  } vec_t;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] divider;
  logic       cpol;
  logic       cs;
  logic       sclk;
  logic       sclk_pe;
  logic       sclk_ne;

  always #5 clk = ~clk;

  spi_sclk_gen dut (
    .clk     (clk),
    .rst     (rst),
    .divider (divider),
    .cpol    (cpol),
    .cs      (cs),
    .sclk    (sclk),
    .sclk_pe (sclk_pe),
    .sclk_ne (sclk_ne)
  );

  // scoreboard
  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic m_sclk;
  int   m_k;
  logic m_s1;
  logic m_s2;

  // per-scenario statistics measured from the DUT
  int   n_pe;
  int   n_ne;
  int   edge_idx;
  int   first_tog;
  logic prev_sclk;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sclk = 1'b0;
    m_k    = 0;
    m_s1   = 1'b1;
    m_s2   = 1'b1;
  endtask

  // driver: apply one clk cycle of inputs, predict, then compare after the edge
  task automatic step(input logic cs_v, input logic cpol_v, input string tag);
    logic       cs_used;
    logic       tog;
    logic [2:0] e;
    logic [2:0] got;
    cs   = cs_v;
    cpol = cpol_v;
`ifdef SPI_SCLK_CS_SYNC_EN
    cs_used = m_s2;
    m_s2    = m_s1;
    m_s1    = cs_v;
`else
    cs_used = cs_v;
`endif
    if (cs_used) begin
      m_sclk = cpol_v;
      m_k    = 0;
      e      = {cpol_v, 2'b00};
    end else begin
      tog = (((m_k + 1) % (1 << int'(divider))) == 0);
      m_k++;
      if (tog) m_sclk = ~m_sclk;
      e = {m_sclk, tog & m_sclk, tog & ~m_sclk};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {sclk, sclk_pe, sclk_ne};
    e   = exp_q.pop_front();
    check($sformatf("%s edge %0d {sclk,pe,ne}", tag, edge_idx + 1), {29'd0, got}, {29'd0, e});
    edge_idx++;
    if (sclk_pe) n_pe++;
    if (sclk_ne) n_ne++;
    if (first_tog < 0 && sclk !== prev_sclk) first_tog = edge_idx;
    prev_sclk = sclk;
  endtask

  task automatic clear_stats(input logic idle_level);
    n_pe      = 0;
    n_ne      = 0;
    edge_idx  = -1;
    first_tog = -1;
    prev_sclk = idle_level;
  endtask

  task automatic run_vec(input vec_t v);
    divider = v.div;
    clear_stats(v.cpol);
    repeat (2 + L) step(1'b1, v.cpol, {v.name, "_idle"});
    clear_stats(v.cpol);
    for (int i = 0; i < v.run; i++) step(1'b0, v.cpol, v.name);
    repeat (L + 2) step(1'b1, v.cpol, {v.name, "_stop"});
    check({v.name, " first toggle edge"}, first_tog, v.exp_first + L);
    check({v.name, " pe count"}, n_pe, v.exp_pe);
    check({v.name, " ne count"}, n_ne, v.exp_ne);
  endtask

  initial begin
    vecs[0] = '{"div0_cpol0",  3'd0, 1'b0, 16,  0,   8, 8};
    vecs[1] = '{"div3_cpol1",  3'd3, 1'b1, 40,  7,   2, 3};
    vecs[2] = '{"div2_abort",  3'd2, 1'b0, 6,   3,   1, 0};
    vecs[3] = '{"div1_cpol1",  3'd1, 1'b1, 10,  1,   2, 3};
    vecs[4] = '{"div7_cpol0",  3'd7, 1'b0, 300, 127, 1, 1};
    vecs[5] = '{"div0_cpol1",  3'd0, 1'b1, 5,   0,   2, 3};

    // reset: outputs low while held, sclk follows cpol one edge after release
    model_reset();
    clear_stats(1'b0);
    rst     = 1'b0;
    cs      = 1'b1;
    cpol    = 1'b1;
    divider = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset sclk", {31'd0, sclk}, 32'd0);
    check("reset sclk_pe", {31'd0, sclk_pe}, 32'd0);
    check("reset sclk_ne", {31'd0, sclk_ne}, 32'd0);
    rst = 1'b1;
    clear_stats(1'b0);
    repeat (3) step(1'b1, 1'b1, "rst_release");
    check("rst_release strobes", n_pe + n_ne, 0);

    // table-driven run scenarios
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // cpol wiggled while running is ignored; new cpol appears on stop, no strobe
    divider = 3'd1;
    clear_stats(1'b0);
    repeat (2 + L) step(1'b1, 1'b0, "cpolchg_idle");
    clear_stats(1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 2), "cpolchg_run");
    check("cpolchg pe count", n_pe, 3);
    check("cpolchg ne count", n_ne, 3);
    n_pe = 0;
    n_ne = 0;
    repeat (L + 2) step(1'b1, 1'b1, "cpolchg_stop");
    check("cpolchg stop strobes", n_pe + n_ne, 0);
    check("cpolchg stop level", {31'd0, sclk}, 32'd1);

    // asynchronous reset in the middle of a run
    divider = 3'd0;
    clear_stats(1'b1);
    for (int i = 0; i < 6 + L; i++) step(1'b0, 1'b1, "midrst_run");
    rst = 1'b0;
    #1;
    check("midrst async {sclk,pe,ne}", {29'd0, sclk, sclk_pe, sclk_ne}, 32'd0);
    model_reset();
    #2;
    rst = 1'b1;
    clear_stats(1'b0);
    repeat (L + 2) step(1'b1, 1'b0, "midrst_after");

    // random scenarios, scoreboard only
    for (int r = 0; r < 8; r++) begin
      logic       c;
      int         n;
      divider = 3'($urandom_range(0, 4));
      c       = 1'($urandom_range(0, 1));
      n       = $urandom_range(1, 50);
      clear_stats(c);
      repeat (2 + L) step(1'b1, c, "rand_idle");
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), "rand_run");
      repeat (L + 2) step(1'b1, c, "rand_stop");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
